// File: rtl/buzzer_sequencer.sv
// Burst pattern generator for the buzzer stage: one start request gives 1-7 beeps
// with programmable on/off times, timed by a 1 ms tick prescaler.
module buzzer_sequencer #(
  parameter int TICK_RLD          = 99_999,
  parameter int TICK_RLD_TURBOSIM = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       turbosim,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] beeps,
  input  logic [7:0] on_ms,
  input  logic [7:0] off_ms,
  output logic       buzz_en,
  output logic       busy,
  output logic       done
);

  localparam int RLD_MAX = (TICK_RLD > TICK_RLD_TURBOSIM) ? TICK_RLD : TICK_RLD_TURBOSIM;
  localparam int PW      = (RLD_MAX > 1) ? $clog2(RLD_MAX + 1) : 1;
  localparam logic [PW-1:0] RLD_NORM  = PW'(TICK_RLD);
  localparam logic [PW-1:0] RLD_TURBO = PW'(TICK_RLD_TURBOSIM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    phase_q, phase_d;
  logic [2:0]    rem_q, rem_d;
  logic [7:0]    on_len_q, on_len_d;
  logic [7:0]    off_len_q, off_len_d;
  logic          buzz_en_q, buzz_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [PW-1:0] reload_s;
  logic          tick_s;
  logic [7:0]    on_min_s;
  logic [7:0]    off_min_s;

  assign reload_s  = turbosim ? RLD_TURBO : RLD_NORM;
  assign tick_s    = (presc_q == {PW{1'b0}});
  assign on_min_s  = (on_ms  == 8'd0) ? 8'd1 : on_ms;
  assign off_min_s = (off_ms == 8'd0) ? 8'd1 : off_ms;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    phase_d   = phase_q;
    rem_d     = rem_q;
    on_len_d  = on_len_q;
    off_len_d = off_len_q;
    done_d    = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      presc_d = reload_s;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = reload_s;
          if (start && (beeps != 3'd0)) begin
            state_d   = S_ON;
            rem_d     = beeps;
            on_len_d  = on_min_s;
            off_len_d = off_min_s;
            phase_d   = on_min_s;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ON, S_OFF: begin
          if (tick_s) begin
            presc_d = reload_s;
            if (phase_q == 8'd1) begin
              if (state_q == S_OFF) begin
                state_d = S_ON;
                phase_d = on_len_q;
              end else if (rem_q > 3'd1) begin
                state_d = S_OFF;
                rem_d   = rem_q - 3'd1;
                phase_d = off_len_q;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              phase_d = phase_q - 8'd1;
            end
          end else begin
            presc_d = presc_q - PW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          presc_d = reload_s;
        end
      endcase
    end

    // Outputs are decoded from the next state so they appear together with it.
    buzz_en_d = (state_d == S_ON);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= {PW{1'b0}};
      phase_q   <= 8'd0;
      rem_q     <= 3'd0;
      on_len_q  <= 8'd0;
      off_len_q <= 8'd0;
      buzz_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      on_len_q  <= on_len_d;
      off_len_q <= off_len_d;
      buzz_en_q <= buzz_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign buzz_en = buzz_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Scoreboard bench: the model predicts output transitions {buzz_en,busy,done} with their
// edge index; a negedge monitor pops one entry per observed change and compares.
module tb_buzzer_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       turbosim = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] beeps = 3'd0;
  logic [7:0] on_ms = 8'd0;
  logic [7:0] off_ms = 8'd0;
  logic       buzz_en, busy, done;

  buzzer_sequencer dut (
    .clk(clk), .reset(reset), .turbosim(turbosim), .start(start), .abort(abort),
    .beeps(beeps), .on_ms(on_ms), .off_ms(off_ms),
    .buzz_en(buzz_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         t;
    logic [2:0] v;
  } ev_t;

  ev_t sc[$];
  ev_t hist[$];
  int  cyc = 0;
  int  busy_until = -1;
  int  n_cmp = 0;
  int  n_bad = 0;
  logic [2:0] prev_v = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output triple must match the next predicted transition.
  always @(negedge clk) begin
    logic [2:0] cur;
    ev_t e;
    cur = {buzz_en, busy, done};
    if (cur !== prev_v) begin
      n_cmp++;
      if (sc.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
      end else begin
        e = sc.pop_front();
        if (e.t != cyc || e.v !== cur) begin
          n_bad++;
          $display("FAIL transition got cyc=%0d val=%b required cyc=%0d val=%b", cyc, cur, e.t, e.v);
        end
      end
      prev_v = cur;
    end
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b required=%b", name, act, exp);
    end
  endtask

  function automatic logic [2:0] last_vals();
    return (hist.size() > 0) ? hist[$].v : 3'b000;
  endfunction

  // Any new prediction at time t overrides what was predicted for t and later.
  task automatic push_ev(input int t, input logic [2:0] v);
    ev_t e;
    while (hist.size() > 0 && hist[$].t >= t) void'(hist.pop_back());
    while (sc.size() > 0 && sc[$].t >= t) void'(sc.pop_back());
    if (last_vals() != v) begin
      e.t = t;
      e.v = v;
      hist.push_back(e);
      sc.push_back(e);
    end
  endtask

  task automatic model_burst(input int n, input int b, input int on, input int off, input int p);
    int t;
    t = n;
    for (int k = 0; k < b; k++) begin
      push_ev(t, 3'b110);
      t += on * p;
      if (k < b - 1) begin
        push_ev(t, 3'b010);
        t += off * p;
      end else begin
        push_ev(t, 3'b001);
        push_ev(t + 1, 3'b000);
      end
    end
    busy_until = t;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic issue(input int b, input int on, input int off);
    int n;
    @(negedge clk); #1;
    beeps = 3'(b); on_ms = 8'(on); off_ms = 8'(off); start = 1'b1;
    n = cyc + 1;
    if (n > busy_until && b != 0)
      model_burst(n, b, (on == 0) ? 1 : on, (off == 0) ? 1 : off, turbosim ? 10 : 100000);
    @(negedge clk); #1;
    start = 1'b0;
    beeps = 3'($urandom_range(0, 7)); on_ms = 8'($urandom); off_ms = 8'($urandom);
  endtask

  task automatic do_abort(input logic with_start);
    int a;
    @(negedge clk); #1;
    abort = 1'b1; start = with_start; beeps = 3'd2; on_ms = 8'd3; off_ms = 8'd2;
    a = cyc + 1;
    push_ev(a, 3'b000);
    if (busy_until >= a) busy_until = a - 1;
    @(negedge clk); #1;
    abort = 1'b0; start = 1'b0;
  endtask

  initial begin
    int w;
    idle(3);
    chk("reset_state", {buzz_en, busy, done}, 3'b000);
    @(negedge clk); #1;
    reset = 1'b0;
    idle(200);
    chk("idle_200", {buzz_en, busy, done}, 3'b000);

    issue(2, 3, 2);   idle(90);
    issue(1, 0, 0);   idle(15);
    issue(3, 1, 0);   idle(60);
    issue(0, 5, 5);   idle(20);
    chk("beeps0_ignored", {buzz_en, busy, done}, 3'b000);
    issue(2, 3, 2);   idle(40);
    issue(2, 3, 2);   idle(50);
    // back-to-back: second start lands on the done cycle
    issue(1, 1, 1);   idle(9);
    issue(1, 2, 1);   idle(30);

    issue(2, 3, 2);   idle(12);
    do_abort(1'b0);   idle(100);
    do_abort(1'b1);   idle(20);
    chk("start_abort_idle", {buzz_en, busy, done}, 3'b000);

    // asynchronous reset between edges during an ON phase
    issue(2, 3, 2);   idle(10);
    @(posedge clk); #2;
    reset = 1'b1;
    push_ev(cyc, 3'b000);
    busy_until = cyc;
    #1;
    chk("async_reset", {buzz_en, busy, done}, 3'b000);
    idle(3);
    @(negedge clk); #1;
    reset = 1'b0;
    busy_until = cyc;
    issue(2, 3, 2);   idle(90);

    // full-rate reload: the first ON must not end within the first 1000 clocks
    turbosim = 1'b0;
    issue(1, 1, 0);   idle(1000);
    chk("slow_tick_on", {buzz_en, busy, done}, 3'b110);
    do_abort(1'b0);
    turbosim = 1'b1;
    idle(20);

    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 30));
        issue($urandom_range(1, 7), $urandom_range(0, 4), $urandom_range(0, 4));
      end
      if ($urandom_range(0, 4) == 0) begin
        idle($urandom_range(0, 40));
        do_abort($urandom_range(0, 1) == 1);
      end
      w = busy_until - cyc + $urandom_range(0, 3);
      if (w < 1) w = 1;
      idle(w);
    end

    idle(5);
    n_cmp++;
    if (sc.size() != 0) begin
      n_bad++;
      $display("FAIL residual_events got=%0d pending required=0 (next cyc=%0d val=%b)",
               sc.size(), sc[0].t, sc[0].v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
